// File: rtl/romc.sv
// rtl/romc.sv - dual-read-port 8x64 DCT-II coefficient ROM with registered outputs
//
// Purpose:
//   Constant ROM of the 8-point DCT-II matrix. Each word is one matrix row,
//   eight signed 8-bit coefficients scaled by 128. Column 0 is the MSB byte:
//   coefficient n sits at bits [63-8n : 56-8n]. Two independent read ports
//   let the row/column datapath fetch two rows per clock.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous active-high reset; clears all output stages
//   addr1  in   3   read address, port 1
//   addr2  in   3   read address, port 2
//   dout1  out  64  registered read data, port 1
//   dout2  out  64  registered read data, port 2
//
// Configuration:
//   ROMC_PIPE2_EN  adds a second register stage on both ports (2-cycle latency).
//                  Undefined by default (1-cycle latency).

module romc (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  addr1,
    input  logic [2:0]  addr2,
    output logic [63:0] dout1,
    output logic [63:0] dout2
);

    // Row k, column n holds round(128 * c(k) * cos((2n+1) k pi / 16)),
    // with c(0) = 1/sqrt(8) and c(k>0) = 1/2.
    function automatic logic [63:0] rom_word(input logic [2:0] a);
        logic [63:0] w;
        w = 64'h0;
        case (a)
            3'd0: w = 64'h2D2D2D2D2D2D2D2D;
            3'd1: w = 64'h3F35240CF4DCCBC1;
            3'd2: w = 64'h3B18E8C5C5E8183B;
            3'd3: w = 64'h35F4C1DC243F0CCB;
            3'd4: w = 64'h2DD3D32D2DD3D32D;
            3'd5: w = 64'h24C10C35CBF43FDC;
            3'd6: w = 64'h18C53BE8E83BC518;
            3'd7: w = 64'h0CDC35C13FCB24F4;
            default: w = 64'h0;
        endcase
        return w;
    endfunction

`ifdef ROMC_PIPE2_EN
    // First stage captures the lookup; second stage is the output flop.
    // Reset clears both so no stale row leaks out after reset.
    logic [63:0] stage1_q;
    logic [63:0] stage2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_q <= 64'h0;
            stage2_q <= 64'h0;
            dout1    <= 64'h0;
            dout2    <= 64'h0;
        end else begin
            stage1_q <= rom_word(addr1);
            stage2_q <= rom_word(addr2);
            dout1    <= stage1_q;
            dout2    <= stage2_q;
        end
    end
`else
    // Outputs are driven straight from flops: no combinational path from
    // address to dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout1 <= 64'h0;
            dout2 <= 64'h0;
        end else begin
            dout1 <= rom_word(addr1);
            dout2 <= rom_word(addr2);
        end
    end
`endif

endmodule

// File: tb/tb_romc.sv
// tb/tb_romc.sv - self-checking testbench for romc with a cosine-derived reference model

`timescale 1ns/1ps

module tb_romc;

`ifdef ROMC_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  addr1;
    logic [2:0]  addr2;
    logic [63:0] dout1;
    logic [63:0] dout2;

    int n_cmp;
    int n_err;

    romc dut (
        .clk   (clk),
        .reset (reset),
        .addr1 (addr1),
        .addr2 (addr2),
        .dout1 (dout1),
        .dout2 (dout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the DCT-II matrix evaluated numerically.
    logic [63:0] model [8];
    logic [63:0] lit   [8];

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(-x + 0.5);
    endfunction

    task automatic build_model();
        real pi;
        real c;
        int  v;
        pi = 3.14159265358979;
        for (int k = 0; k < 8; k++) begin
            model[k] = 64'h0;
            c = (k == 0) ? 1.0 / $sqrt(8.0) : 0.5;
            for (int n = 0; n < 8; n++) begin
                v = rnd(128.0 * c * $cos(real'((2 * n + 1) * k) * pi / 16.0));
                model[k][63 - 8 * n -: 8] = v[7:0];
            end
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model of the read pipeline: address sampled at an edge shows up
    // LAT edges later; reset zeroes everything in flight.
    logic [63:0] e1a, e2a, e1b, e2b;
    logic        mvalid;
    initial mvalid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            e1a = 64'h0; e2a = 64'h0; e1b = 64'h0; e2b = 64'h0;
            mvalid = 1'b1;
        end else begin
            e1b = e1a;
            e2b = e2a;
            e1a = model[addr1];
            e2a = model[addr2];
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check64("cyc_dout1", dout1, (LAT == 2) ? e1b : e1a);
            check64("cyc_dout2", dout2, (LAT == 2) ? e2b : e2a);
        end
    end

    task automatic drive(input logic [2:0] a1, input logic [2:0] a2, input logic r);
        @(negedge clk);
        #1;
        addr1 = a1;
        addr2 = a2;
        reset = r;
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic signed [7:0] blo, bhi;
    logic              sym_ok;

    initial begin
        n_cmp = 0;
        n_err = 0;
        addr1 = 3'd7;
        addr2 = 3'd3;
        reset = 1'b1;

        lit[0] = 64'h2D2D2D2D2D2D2D2D;
        lit[1] = 64'h3F35240CF4DCCBC1;
        lit[2] = 64'h3B18E8C5C5E8183B;
        lit[3] = 64'h35F4C1DC243F0CCB;
        lit[4] = 64'h2DD3D32D2DD3D32D;
        lit[5] = 64'h24C10C35CBF43FDC;
        lit[6] = 64'h18C53BE8E83BC518;
        lit[7] = 64'h0CDC35C13FCB24F4;
        build_model();
        for (int k = 0; k < 8; k++) check64($sformatf("model_pin_%0d", k), model[k], lit[k]);

        // Reset held for two edges.
        edges(2);
        check64("rst_dout1", dout1, 64'h0);
        check64("rst_dout2", dout2, 64'h0);
        #1;
        reset = 1'b0;
        edges(LAT);
        check64("post_rst_dout1", dout1, 64'h0CDC35C13FCB24F4);
        check64("post_rst_dout2", dout2, 64'h35F4C1DC243F0CCB);

        // Crossed sweep, with a one-edge reset in the middle.
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 3'(7 - i), 1'b0);
            if (i == 4) begin
                drive(3'(i), 3'(7 - i), 1'b1);
                @(negedge clk);
                check64("midrst_dout1", dout1, 64'h0);
                check64("midrst_dout2", dout2, 64'h0);
                #1;
                reset = 1'b0;
            end
        end
        edges(LAT);
        check64("sweep_end_dout1", dout1, 64'h0CDC35C13FCB24F4);
        check64("sweep_end_dout2", dout2, 64'h2D2D2D2D2D2D2D2D);
        edges(4);
        check64("hold_dout1", dout1, 64'h0CDC35C13FCB24F4);
        check64("hold_dout2", dout2, 64'h2D2D2D2D2D2D2D2D);

        // Same address on both ports.
        drive(3'd4, 3'd4, 1'b0);
        edges(LAT);
        check64("same_dout1", dout1, 64'h2DD3D32D2DD3D32D);
        check64("same_dout2", dout2, 64'h2DD3D32D2DD3D32D);

        // Latency: addr1 1 -> 2 between edges.
        drive(3'd1, 3'd0, 1'b0);
        edges(LAT);
        check64("lat_before", dout1, 64'h3F35240CF4DCCBC1);
        #1;
        addr1 = 3'd2;
        #2;
        check64("lat_between", dout1, 64'h3F35240CF4DCCBC1);
        @(negedge clk);
        check64("lat_edge1", dout1, (LAT == 1) ? 64'h3B18E8C5C5E8183B : 64'h3F35240CF4DCCBC1);
        @(negedge clk);
        check64("lat_edge2", dout1, 64'h3B18E8C5C5E8183B);

        // Symmetry of each row, derived from the DUT outputs.
        for (int k = 0; k < 8; k++) begin
            drive(3'(k), 3'(k), 1'b0);
            edges(LAT);
            sym_ok = 1'b1;
            for (int n = 0; n < 4; n++) begin
                blo = dout1[63 - 8 * n -: 8];
                bhi = dout1[63 - 8 * (7 - n) -: 8];
                if ((k % 2) == 0) begin
                    if (bhi != blo) sym_ok = 1'b0;
                end else begin
                    if (bhi != -blo) sym_ok = 1'b0;
                end
            end
            n_cmp++;
            if (!sym_ok) begin
                n_err++;
                $display("FAIL symmetry_row_%0d: got %h, mirrored bytes do not satisfy row parity rule", k, dout1);
            end
        end

        // Random traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
        end
        drive(3'd0, 3'd0, 1'b0);
        edges(LAT + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
